// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the chunk-serial adder/subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice, reused for every chunk.
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Chunk-serial add/subtract: one CHUNK-bit slice per clock, N clocks per op.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = num_chunks(WIDTH, CHUNK);
    localparam int CW = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [CHUNK-1:0]  x, y, s;
    logic              c_out, c_msb;

    always_comb begin
        x = '0;
        y = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                x = a_q[k*CHUNK +: CHUNK];
                y = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x    (x),
        .y    (y),
        .cin  (carry_q),
        .s    (s),
        .cout (c_out),
        .c_msb(c_msb)
    );

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    // Sum is built in acc_q so the visible result only changes on completion.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) begin
                        acc_d[k*CHUNK +: CHUNK] = s;
                    end
                end
                carry_d = c_out;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    result_d = acc_d;
                    cout_d   = c_out;
                    ovf_d    = c_msb ^ c_out;
                    zero_d   = (acc_d == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench: directed 32/8 checks plus random 16-bit chunk sweeps.
module tb_addsub_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main DUT: WIDTH=32, CHUNK=8 ----------------
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        cout, overflow, zero;

    addsub_serial #(.WIDTH(32), .CHUNK(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    exp_t q32[$];
    exp_t e32;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q32.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0h want none", result);
            end else begin
                e32 = q32.pop_front();
                chk("result", result, e32.r);
                chk("cout", cout, e32.c);
                chk("overflow", overflow, e32.o);
                chk("zero", zero, e32.z);
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        chk("in_ready_wait", in_ready, 1);
    endtask

    // Accept one op, then scribble on the inputs while the block is busy.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                         input logic s);
        wait_ready();
        in_valid = 1'b1;
        a = av;
        b = bv;
        sub = s;
        tick();
        a = $urandom;
        b = $urandom;
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          input logic s, input logic [31:0] er,
                          input logic ec, input logic eo, input logic ez);
        int lat;
        q32.push_back(exp_t'({er, ec, eo, ez}));
        out_ready = 1'b1;
        issue(av, bv, s);
        wait_valid(lat);
        chk("latency", lat, 4);
        tick();
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
    endtask

    // ---------------- sweep DUTs: WIDTH=16 ----------------
    logic rst_s = 1'b1;

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int CH  = (g == 0) ? 16 : ((g == 1) ? 1 : 4);
        localparam int LAT = 16 / CH;

        logic        iv = 1'b0;
        logic        ir;
        logic [15:0] av = '0;
        logic [15:0] bv = '0;
        logic        sb = 1'b0;
        logic        ov;
        logic        orr = 1'b0;
        logic [15:0] res;
        logic        co, ofl, zr;
        bit          done_s = 1'b0;

        typedef struct packed {
            logic [15:0] r;
            logic        c;
            logic        o;
            logic        z;
        } e16_t;

        e16_t q[$];
        e16_t e;

        addsub_serial #(.WIDTH(16), .CHUNK(CH)) dut_s (
            .clk      (clk),
            .rst      (rst_s),
            .in_valid (iv),
            .in_ready (ir),
            .a        (av),
            .b        (bv),
            .sub      (sb),
            .out_valid(ov),
            .out_ready(orr),
            .result   (res),
            .cout     (co),
            .overflow (ofl),
            .zero     (zr)
        );

        always @(negedge clk) begin
            if (!rst_s && ov && orr) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sw_unexpected: got %0h want none", res);
                end else begin
                    e = q.pop_front();
                    chk("sw_result", res, e.r);
                    chk("sw_cout", co, e.c);
                    chk("sw_overflow", ofl, e.o);
                    chk("sw_zero", zr, e.z);
                end
            end
        end

        initial begin
            wait (!rst_s);
            tick();
            for (int n = 0; n < 1000; n++) begin
                logic [16:0] sum;
                logic [15:0] bx;
                int          lat;
                int          gd;
                gd = 0;
                while (!ir && gd < 100) begin
                    tick();
                    gd++;
                end
                chk("sw_ready", ir, 1);
                av = 16'($urandom);
                bv = 16'($urandom);
                sb = 1'($urandom_range(0, 1));
                bx = bv ^ {16{sb}};
                sum = {1'b0, av} + {1'b0, bx} + {16'd0, sb};
                q.push_back(e16_t'({sum[15:0], sum[16],
                    (av[15] == bx[15]) && (sum[15] != av[15]),
                    sum[15:0] == 16'd0}));
                iv = 1'b1;
                tick();
                iv = 1'b0;
                lat = 0;
                while (!ov && lat < 100) begin
                    tick();
                    lat++;
                end
                chk("sw_latency", lat, LAT);
                gd = 0;
                while (ov && gd < 100) begin
                    orr = 1'($urandom_range(0, 1));
                    tick();
                    gd++;
                end
                chk("sw_drain", ov, 0);
                orr = 1'b0;
            end
            done_s = 1'b1;
        end
    end

    // ---------------- main directed sequence ----------------
    initial begin
        int lat;
        int gd;
        tick();
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_outputs", {result, cout, overflow, zero}, 0);
        rst = 1'b0;
        rst_s = 1'b0;
        #1;
        chk("rst_release_ready", in_ready, 1);

        run_op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1, 0, 1);
        run_op(32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1, 0, 0);
        run_op(32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 0, 0, 0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1, 1, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1, 0, 1);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 0, 1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1, 1, 1);

        // Backpressure: result must sit still while inputs churn.
        q32.push_back(exp_t'({32'h2345_6789, 1'b0, 1'b0, 1'b0}));
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_valid(lat);
        chk("bp_latency", lat, 4);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            sub = 1'($urandom_range(0, 1));
            tick();
            chk("bp_result", result, 32'h2345_6789);
            chk("bp_flags", {cout, overflow, zero}, 3'b000);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) tick();
        chk("bp_no_accept", out_valid, 0);
        chk("bp_idle_ready", in_ready, 1);

        // Reset during CALC, while chunk 2 is being processed.
        wait_ready();
        in_valid = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'h0123_4567;
        sub = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rc_out_valid", out_valid, 0);
        chk("rc_outputs", {result, cout, overflow, zero}, 0);
        chk("rc_in_ready_rst", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rc_in_ready", in_ready, 1);
        run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 32'hDFD1_0456, 0, 0, 0);

        // Reset while holding a finished result.
        out_ready = 1'b0;
        issue(32'h0000_0010, 32'h0000_0020, 1'b1);
        wait_valid(lat);
        chk("rd_latency", lat, 4);
        rst = 1'b1;
        tick();
        chk("rd_out_valid", out_valid, 0);
        chk("rd_outputs", {result, cout, overflow, zero}, 0);
        rst = 1'b0;
        #1;
        chk("rd_in_ready", in_ready, 1);
        run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 32'hFFFF_FFF0, 0, 0, 0);

        gd = 0;
        while (!(g_sw[0].done_s && g_sw[1].done_s && g_sw[2].done_s)
               && gd < 60000) begin
            tick();
            gd++;
        end
        chk("sweep_finished",
            {g_sw[0].done_s, g_sw[1].done_s, g_sw[2].done_s}, 3'b111);
        chk("queue_empty", q32.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 8, bits processed per clock; SHALL divide WIDTH exactly, with N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand request.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  minuend/augend.
REQ-008 b  input  WIDTH  subtrahend/addend.
REQ-009 sub  input  1  1 = a - b, 0 = a + b.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-013 cout  output  1  final carry; for sub, 1 = no borrow (a >= b unsigned).
REQ-014 overflow  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  result == 0.

Function
REQ-016 The FSM SHALL have states IDLE, CALC and DONE; in_ready = 1 only in IDLE with rst low; out_valid = 1 only in DONE.
REQ-017 Acceptance occurs on the rising edge at which in_valid and in_ready are both 1: the block latches a, b and sub, sets the chunk counter to 0, sets carry-in to sub, and enters CALC.
REQ-018 Subtraction SHALL be computed as a + ~b + 1; the +1 is the initial carry-in, not a separate adder.
REQ-019 Each CALC edge SHALL add chunk k of a and of (b XOR {WIDTH{sub}}) plus the stored carry, write result bits [k*CHUNK +: CHUNK], store the chunk carry-out, and increment k.
REQ-020 On the edge processing chunk N-1, the block SHALL load cout = final carry, overflow = carry into MSB XOR carry out of MSB, and zero, then enter DONE. out_valid therefore rises exactly N edges after the acceptance edge.
REQ-021 DONE SHALL hold result, cout, overflow and zero stable while out_ready = 0, for any duration.
REQ-022 In DONE with out_ready = 1, the edge SHALL move the block to IDLE; in_ready is asserted from the next cycle. Back-to-back throughput is therefore one op per N+2 cycles.
REQ-023 Changes on a, b, sub or in_valid outside IDLE SHALL have no effect.
REQ-024 result, cout, overflow and zero SHALL keep their last values in IDLE and CALC. Consumers qualify them only with out_valid.
REQ-025 When N = 1, CALC SHALL last exactly one edge, and the general rules need no special case.

Reset
REQ-026 When rst = 1 at an edge, the block SHALL enter IDLE and clear the counter, carry, result, cout, overflow and zero to 0; out_valid = 0. This applies in any state, including mid-CALC and in DONE, and discards any pending result.
REQ-027 in_ready SHALL be 0 while rst = 1, and 1 in the first cycle after rst is released.

Structure
REQ-028 A shared package addsub_pkg SHALL hold the state enumeration (IDLE, CALC, DONE) and a constant function computing N and the counter width ($clog2(N), minimum 1).
REQ-029 One sub-module, addsub_chunk, SHALL be a combinational CHUNK-bit ripple full-adder chain with inputs x, y, cin and outputs s, cout, and carry into its MSB. It is instantiated once and time-multiplexed across chunks.
REQ-030 Parameter legality (WIDTH % CHUNK == 0, WIDTH >= 2) SHALL be checked at elaboration and abort with an error.

Verification
REQ-031 Add test, WIDTH=32, CHUNK=8: a=0x0000_0001, b=0xFFFF_FFFF, sub=0. Required: result 0x0000_0000, cout 1, zero 1, overflow 0; out_valid rises 4 edges after acceptance.
REQ-032 Subtract tests: sub 5-3 -> result 0x0000_0002, cout 1. Sub 3-5 -> result 0xFFFF_FFFE, cout 0, overflow 0.
REQ-033 Signed overflow tests: sub 0x8000_0000-0x0000_0001 -> result 0x7FFF_FFFF, overflow 1. Add 0x7FFF_FFFF+1 -> result 0x8000_0000, overflow 1.
REQ-034 Backpressure test: hold out_ready=0 for 10 cycles in DONE while toggling in_valid, a and b. Required: outputs unchanged, in_ready 0, no new acceptance. Then out_ready=1 -> IDLE, and in_ready=1 one cycle later.
REQ-035 Reset tests: pulse rst for 1 cycle during CALC chunk 2 -> IDLE, out_valid 0, all outputs 0, in_ready 1 the next cycle, and the following op computes correctly. Repeat with rst asserted in DONE.
REQ-036 Parameter sweep: WIDTH=16 with CHUNK=16 (latency 1), CHUNK=1 (latency 16) and CHUNK=4, using 1000 random ops each. Required: all outputs match a reference model bit-exactly.
